// File: rtl/button_event_queue.sv
// Turns debounced button levels into a FIFO of press/release events.
// Define BUTTON_EVENT_REPEAT_EN to build auto-repeat of the most recently pressed button.
module button_event_queue #(
  parameter int COUNT      = 8,
  parameter int IDX_BITS   = 3,
  parameter int DEPTH_LOG2 = 3,
  parameter int DELAY_BITS = 22,
  parameter int RATE_BITS  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COUNT-1:0]      in,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic                  ev_press,
  output logic                  ev_repeat,
  output logic [IDX_BITS-1:0]   ev_index,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic                press;
    logic [IDX_BITS-1:0] idx;
  } ev_t;

  generate
    if (COUNT > (1 << IDX_BITS) || COUNT < 1 || DELAY_BITS < 1 || RATE_BITS < 1) begin : g_bad_params
      $error("button_event_queue: illegal parameter combination");
    end
  endgenerate

  logic [COUNT-1:0]      reported_q, reported_d;
  logic [COUNT-1:0]      diff, chg_mask;
  logic                  chg_any, chg_press, chg_push;
  logic [IDX_BITS-1:0]   chg_idx;
  logic                  full, pop, push, rpt_push;
  logic [IDX_BITS-1:0]   rpt_tgt;
  ev_t                   push_ev;
  ev_t [DEPTH-1:0]       mem_q, mem_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  // Lowest-index changed button wins; the rest wait for later cycles.
  always_comb begin
    diff      = in ^ reported_q;
    chg_any   = |diff;
    chg_mask  = '0;
    chg_idx   = '0;
    chg_press = 1'b0;
    for (int i = COUNT - 1; i >= 0; i--) begin
      if (diff[i]) begin
        chg_mask    = '0;
        chg_mask[i] = 1'b1;
        chg_idx     = IDX_BITS'(i);
        chg_press   = in[i];
      end
    end
  end

  assign ev_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign full       = (count_q == CW'(DEPTH));
  assign pop        = ev_valid && ev_ready;
  assign chg_push   = chg_any && !full;
  assign push       = chg_push || rpt_push;

  // While full, reported holds, so pending changes coalesce into the final level.
  always_comb begin
    reported_d = reported_q;
    if (chg_push) reported_d = (reported_q & ~chg_mask) | (in & chg_mask);
  end

  always_comb begin
    push_ev = '0;
    if (chg_push) begin
      push_ev.press = chg_press;
      push_ev.idx   = chg_idx;
    end else begin
      push_ev.press = 1'b1;
      push_ev.idx   = rpt_tgt;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_ev;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reported_q <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      reported_q <= reported_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign ev_press = mem_q[rd_ptr_q].press;
  assign ev_index = mem_q[rd_ptr_q].idx;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int TW = (DELAY_BITS > RATE_BITS) ? DELAY_BITS : RATE_BITS;

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_RATE, RPT_DUE} rpt_state_e;

  rpt_state_e          state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d, timer_inc;
  logic [IDX_BITS-1:0] rpt_idx_q, rpt_idx_d;
  logic                rpt_held;
  logic [DEPTH-1:0]    rbit_q, rbit_d;

  assign rpt_held  = reported_q[rpt_idx_q];
  assign timer_inc = timer_q + 1'b1;
  assign rpt_tgt   = rpt_idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RPT_IDLE;
      timer_q   <= '0;
      rpt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rpt_idx_q <= rpt_idx_d;
    end
  end

  // Timer lands on all-ones as DUE is entered, so the DUE cycle completes the period.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rpt_idx_d = rpt_idx_q;
    if (chg_push && chg_press) begin
      rpt_idx_d = chg_idx;
      timer_d   = '0;
      state_d   = RPT_DELAY;
    end else if (!rpt_held) begin
      timer_d = '0;
      state_d = RPT_IDLE;
    end else begin
      case (state_q)
        RPT_DELAY: begin
          timer_d = timer_inc;
          if (&timer_inc[DELAY_BITS-1:0]) state_d = RPT_DUE;
        end
        RPT_RATE: begin
          timer_d = timer_inc;
          if (&timer_inc[RATE_BITS-1:0]) state_d = RPT_DUE;
        end
        RPT_DUE: begin
          if (rpt_push) begin
            timer_d = '0;
            state_d = RPT_RATE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rpt_push = (state_q == RPT_DUE) && !chg_any && !full && rpt_held;
  end

  always_comb begin
    rbit_d = rbit_q;
    if (push) rbit_d[wr_ptr_q] = !chg_push;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rbit_q <= '0;
    else       rbit_q <= rbit_d;
  end

  assign ev_repeat = rbit_q[rd_ptr_q];
`else
  assign rpt_push  = 1'b0;
  assign rpt_tgt   = '0;
  assign ev_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_queue.sv
// Randomised and directed bench for button_event_queue against a queue-based event model.
module tb_button_event_queue;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int  DB = 4;
  localparam int  RB = 2;
  localparam bit  RPT_EN = 1'b1;
`else
  localparam int  DB = 22;
  localparam int  RB = 20;
  localparam bit  RPT_EN = 1'b0;
`endif

  logic       clk, reset, ev_ready;
  logic [7:0] in_r;
  logic       ev_valid, ev_press, ev_repeat;
  logic [2:0] ev_index;
  logic [3:0] fifo_count;

  button_event_queue #(
    .COUNT(8), .IDX_BITS(3), .DEPTH_LOG2(3), .DELAY_BITS(DB), .RATE_BITS(RB)
  ) dut (
    .clk(clk), .reset(reset), .in(in_r),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_press(ev_press),
    .ev_repeat(ev_repeat), .ev_index(ev_index), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of {repeat, press, index}, plus level memory and repeat deadline.
  logic [4:0] m_q[$];
  logic [7:0] m_rep;
  longint     m_t, m_due;
  bit         m_act;
  int         m_idx;

  task automatic model_reset();
    m_q.delete();
    m_rep = '0;
    m_t   = 0;
    m_due = 0;
    m_act = 1'b0;
    m_idx = 0;
  endtask

  task automatic model_step();
    int         sz = m_q.size();
    bit         full = (sz == 8);
    logic [7:0] diff = in_r ^ m_rep;
    int         li = -1;
    if (m_act && !m_rep[m_idx]) m_act = 1'b0;
    if (sz > 0 && ev_ready) void'(m_q.pop_front());
    for (int i = 0; i < 8; i++) if (diff[i] && li < 0) li = i;
    if (li >= 0 && !full) begin
      m_q.push_back({1'b0, in_r[li], 3'(li)});
      m_rep[li] = in_r[li];
      if (in_r[li] && RPT_EN) begin
        m_act = 1'b1;
        m_idx = li;
        m_due = m_t + (longint'(1) << DB);
      end
    end else if (RPT_EN && m_act && m_t >= m_due && !full) begin
      m_q.push_back({1'b1, 1'b1, 3'(m_idx)});
      m_due = m_t + (longint'(1) << RB);
    end
    m_t++;
  endtask

  function automatic logic [9:0] exp_vec();
    int sz = m_q.size();
    return {sz != 0, 4'(sz), (sz != 0) ? m_q[0] : 5'b0};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {ev_valid, fifo_count, ev_valid ? {ev_repeat, ev_press, ev_index} : 5'b0};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ev_ready = 1'b0;
    in_r     = 8'h05;
    reset    = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ev_valid, ev_press, ev_repeat, ev_index} !== 6'b0) $display("FAIL reset_outs: got %b required 000000", {ev_valid, ev_press, ev_repeat, ev_index});
    else n_pass++;
    n_checks++;
    if (fifo_count !== 4'd0) $display("FAIL reset_count: got %0d required 0", fifo_count);
    else n_pass++;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin
        n_checks++;
        if ({ev_valid, ev_press, ev_index} !== 5'b11000) $display("FAIL reset_first_ev: got %b required 11000", {ev_valid, ev_press, ev_index});
        else n_pass++;
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset_held: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (fifo_count !== 4'd2) $display("FAIL reset_peak: got %0d required 2", fifo_count);
    else n_pass++;
    ev_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset_drain: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_press_release();
    logic [7:0] seq [0:2] = '{8'h00, 8'h01, 8'h00};
    ev_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      in_r = seq[s];
      for (int k = 0; k < 4; k++) begin
        tick();
        if (s > 0 && k == 0) begin
          n_checks++;
          if ({ev_valid, ev_press, ev_index} !== {1'b1, seq[s][0], 3'd0}) $display("FAIL pr_latency: got %b required %b", {ev_valid, ev_press, ev_index}, {1'b1, seq[s][0], 3'd0});
          else n_pass++;
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL press_release: got %h required %h", obs_vec(), exp_vec());
        else n_pass++;
      end
    end
    n_checks++;
    if (fifo_count !== 4'd0) $display("FAIL pr_empty: got %0d required 0", fifo_count);
    else n_pass++;
  endtask

  task automatic test_full_coalesce();
    ev_ready = 1'b0;
    in_r = 8'h7F;
    repeat (7) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL fill: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
    in_r = 8'h78;
    repeat (3) tick();
    n_checks++;
    if ({ev_valid, fifo_count} !== 5'b11000) $display("FAIL full_count: got %b required 11000", {ev_valid, fifo_count});
    else n_pass++;
    in_r = 8'hF8;
    tick();
    in_r = 8'h78;
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL coalesce: got %h required %h", obs_vec(), exp_vec());
    else n_pass++;
    ev_ready = 1'b1;
    repeat (12) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL drain: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_full_pop_push();
    ev_ready = 1'b0;
    in_r = 8'h87;
    repeat (8) tick();
    in_r = 8'h86;
    ev_ready = 1'b1;
    tick();
    n_checks++;
    if (fifo_count !== 4'd7) $display("FAIL pop_full_refuse: got %0d required 7", fifo_count);
    else n_pass++;
    ev_ready = 1'b0;
    tick();
    n_checks++;
    if (fifo_count !== 4'd8) $display("FAIL pop_full_land: got %0d required 8", fifo_count);
    else n_pass++;
    ev_ready = 1'b1;
    repeat (10) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL pop_push_drain: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reset_flush();
    ev_ready = 1'b0;
    in_r = 8'h0F;
    repeat (3) tick();
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({ev_valid, fifo_count} !== 5'b0) $display("FAIL flush: got %b required 00000", {ev_valid, fifo_count});
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL post_flush: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 39) == 0) in_r[b] = ~in_r[b];
      ev_ready = ($urandom_range(0, 9) < 7);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL random c=%0d: got %h required %h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    in_r = 8'h00;
    ev_ready = 1'b1;
    repeat (20) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL random_drain: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

`ifdef BUTTON_EVENT_REPEAT_EN
  task automatic test_repeat_hold();
    int nrep = 0;
    ev_ready = 1'b1;
    in_r = 8'h08;
    repeat (40) begin
      tick();
      if (ev_valid && ev_repeat) nrep++;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL repeat_hold: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (nrep !== 6) $display("FAIL repeat_count: got %0d required 6", nrep);
    else n_pass++;
    nrep = 0;
    in_r = 8'h00;
    repeat (30) begin
      tick();
      if (ev_valid && ev_repeat) nrep++;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL repeat_release: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (nrep !== 0) $display("FAIL repeat_after_release: got %0d required 0", nrep);
    else n_pass++;
  endtask

  task automatic test_repeat_collide();
    ev_ready = 1'b1;
    in_r = 8'h02;
    repeat (2) tick();
    in_r = 8'h0A;
    tick();
    for (int k = 0; k < 100 && m_t < m_due; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL collide_wait: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
    in_r = 8'h08;
    tick();
    n_checks++;
    if ({ev_valid, ev_repeat, ev_press, ev_index} !== 6'b100001) $display("FAIL collide_change: got %b required 100001", {ev_valid, ev_repeat, ev_press, ev_index});
    else n_pass++;
    tick();
    n_checks++;
    if ({ev_valid, ev_repeat, ev_press, ev_index} !== 6'b111011) $display("FAIL collide_repeat: got %b required 111011", {ev_valid, ev_repeat, ev_press, ev_index});
    else n_pass++;
    in_r = 8'h00;
    repeat (6) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL collide_tail: got %h required %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    in_r     = 8'h00;
    ev_ready = 1'b0;
    #1;
    test_reset();
    test_press_release();
    test_full_coalesce();
    test_full_pop_push();
    test_reset_flush();
    test_random();
`ifdef BUTTON_EVENT_REPEAT_EN
    test_repeat_hold();
    test_repeat_collide();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
